// File: rtl/day_set_ctrl_if.sv
// Front-panel / day-counter bundle for day_set_ctrl.
// LD and EN_OUT form a one-cycle strobe with DAY_OUT valid alongside; the counter always accepts, so there is no ready.
interface day_set_ctrl_if;
  logic       Btn_Set;
  logic       Btn_Up;
  logic       Btn_Dn;
  logic [2:0] Cur_Day;
  logic [2:0] DAY_OUT;
  logic       LD;
  logic       EN_OUT;
  logic       Editing;
  logic [2:0] Edit_Day;
  logic [1:0] state_dbg;

  modport slave (
    input  Btn_Set, Btn_Up, Btn_Dn, Cur_Day,
    output DAY_OUT, LD, EN_OUT, Editing, Edit_Day, state_dbg
  );

  modport master (
    output Btn_Set, Btn_Up, Btn_Dn, Cur_Day,
    input  DAY_OUT, LD, EN_OUT, Editing, Edit_Day, state_dbg
  );
endinterface

// File: rtl/day_set_ctrl.sv
// Button-driven editor for the 0..6 day counter: debounce, edit with wrap, commit via one-cycle load.
// Optional hold-to-repeat stepping is built only when AUTO_REPEAT_EN is defined.
module day_set_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 64
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DLY   = 8,
  parameter int REPEAT_RATE  = 4
`endif
) (
  input  logic          Clk,
  input  logic          Clr,
  day_set_ctrl_if.slave bus
);

  localparam int DBW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int TOW   = $clog2(TIMEOUT_CYC + 1);
  localparam int B_SET = 0;
  localparam int B_UP  = 1;
  localparam int B_DN  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     deb_q, deb_d;
  logic [DBW-1:0] dcnt_q [3];
  logic [DBW-1:0] dcnt_d [3];
  logic [2:0]     press;
  logic [TOW-1:0] to_q, to_d;
  logic           to_expire;
  logic [2:0]     edit_day_q, edit_day_d;
  logic [2:0]     day_out_q, day_out_d;
  logic           ld_q, ld_d;
  logic           en_q, en_d;
  logic           editing;
  logic           rep_up, rep_dn;
  logic           step_up, step_dn;
  logic           any_evt;

  function automatic logic [2:0] day_inc(input logic [2:0] d);
    return (d >= 3'd6) ? 3'd0 : d + 3'd1;
  endfunction

  function automatic logic [2:0] day_dec(input logic [2:0] d);
    return (d == 3'd0 || d == 3'd7) ? 3'd6 : d - 3'd1;
  endfunction

  assign raw = {bus.Btn_Dn, bus.Btn_Up, bus.Btn_Set};

  // A level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DBW'(DEBOUNCE_CYC - 1)) deb_d[i] = sync2_q[i];
        else dcnt_d[i] = dcnt_q[i] + DBW'(1);
      end
    end
    press = deb_d & ~deb_q;
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPM = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPW = $clog2(RPM + 1);

  logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_first_q, rep_first_d;
  logic           held_up, held_dn;
  logic [RPW-1:0] rep_thr;

  // Counts held cycles since the last step; the first gap is longer than the rest.
  always_comb begin
    held_up     = deb_q[B_UP] & ~deb_q[B_DN];
    held_dn     = deb_q[B_DN] & ~deb_q[B_UP];
    rep_thr     = rep_first_q ? RPW'(REPEAT_DLY) : RPW'(REPEAT_RATE);
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    rep_up      = 1'b0;
    rep_dn      = 1'b0;
    if (state_q == ST_EDIT && press == 3'b000 && (held_up || held_dn)) begin
      rep_first_d = rep_first_q;
      if (rep_cnt_q + RPW'(1) == rep_thr) begin
        rep_up      = held_up;
        rep_dn      = held_dn;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + RPW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  assign step_up = press[B_UP] | rep_up;
  assign step_dn = press[B_DN] | rep_dn;
  assign any_evt = (|press) | rep_up | rep_dn;

  always_comb begin
    to_d      = '0;
    to_expire = 1'b0;
    if (state_q == ST_EDIT && !any_evt) begin
      if (to_q == TOW'(TIMEOUT_CYC - 1)) begin
        to_expire = 1'b1;
        to_d      = to_q;
      end else begin
        to_d = to_q + TOW'(1);
      end
    end
  end

  always_comb begin
    edit_day_d = edit_day_q;
    if (state_q == ST_IDLE && press[B_SET]) begin
      edit_day_d = (bus.Cur_Day == 3'd7) ? 3'd0 : bus.Cur_Day;
    end else if (state_q == ST_EDIT && !press[B_SET]) begin
      if (step_up && !step_dn) edit_day_d = day_inc(edit_day_q);
      else if (step_dn && !step_up) edit_day_d = day_dec(edit_day_q);
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (press[B_SET]) state_d = ST_EDIT;
      ST_EDIT: begin
        if (press[B_SET])   state_d = ST_COMMIT;
        else if (to_expire) state_d = ST_IDLE;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobe flops are loaded from the next state so they are high exactly during COMMIT.
  always_comb begin
    ld_d      = (state_d == ST_COMMIT);
    en_d      = ld_d;
    day_out_d = day_out_q;
    if (ld_d) day_out_d = edit_day_q;
    editing   = (state_q == ST_EDIT);
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
      to_q       <= '0;
      edit_day_q <= '0;
      day_out_q  <= '0;
      ld_q       <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
      to_q       <= to_d;
      edit_day_q <= edit_day_d;
      day_out_q  <= day_out_d;
      ld_q       <= ld_d;
      en_q       <= en_d;
    end
  end

  assign bus.DAY_OUT   = day_out_q;
  assign bus.LD        = ld_q;
  assign bus.EN_OUT    = en_q;
  assign bus.Editing   = editing;
  assign bus.Edit_Day  = edit_day_q;
  assign bus.state_dbg = state_q;

endmodule
